serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around the existing 1-bit full_adder cell. It is the sequencing stage that feeds that cell one operand bit pair per clock and consumes its sum and carry.
- Operands are captured on a start handshake and processed LSB first. The carry is held in a flip-flop between bits.
- Result is presented in parallel with a one-cycle done pulse.
- Used where area matters more than latency, for example multi-cycle ALU ops in the CPU datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- START  input  1  request; sampled only when not BUSY.
- A  input  WIDTH  operand A; captured on the accepted START.
- B  input  WIDTH  operand B; captured on the accepted START.
- CI  input  1  carry-in; captured on the accepted START.
- BUSY  output  1  high while bits are being processed.
- DONE  output  1  one-cycle pulse: SUM and CO are valid.
- SUM  output  WIDTH  result A+B+CI, low WIDTH bits.
- CO  output  1  carry-out of the MSB.

Behaviour:
- Reset: at an RST edge, regardless of state:
  - state <= IDLE; BUSY, DONE, SUM, CO all 0.
  - Internal shift registers, carry flop and bit counter cleared.
  - Reset mid-operation aborts the operation with no DONE.
- State IDLE: BUSY=0, DONE=0.
  - START=1 at edge E0: capture A, B, CI into the operand shift registers and carry flop; count <= 0; go to RUN.
- State RUN: BUSY=1.
  - Each edge: the full_adder takes opA[0], opB[0] and carry; its SO is shifted into the MSB of the sum shift register; carry <= CO.
  - Operand registers shift right by 1; count increments.
  - At the edge where count == WIDTH-1 (edge E0+WIDTH):
    - SUM <= {SO, sumshift[WIDTH-1:1]}; CO <= adder CO; go to DONE.
- State DONE: BUSY=0, DONE=1 for exactly one cycle.
  - START=1 here is accepted exactly as in IDLE (back-to-back; next state RUN).
  - Otherwise next state is IDLE.
- Latency:
  - DONE is high in the cycle following edge E0+WIDTH.
  - BUSY is high for exactly WIDTH cycles.
  - Throughput is one add per WIDTH+1 cycles with back-to-back START.
- START while BUSY is ignored: no queueing, no error flag.
- A, B and CI may change freely after the accepted START; they have no effect until the next accepted START.
- SUM and CO hold their last result until the next completion or reset. They are not disturbed during a following RUN.
- Arithmetic is unsigned modulo 2^WIDTH. CO = bit WIDTH of A+B+CI.
- count width is $clog2(WIDTH). The counter never wraps past WIDTH-1.

Decomposition:
- Shared package holds:
  - state encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the WIDTH range limits.
- Sub-module: exactly one instance of the existing full_adder (A, B, CI, SO, CO) as the bit slice.
- All sequencing, shift registers and the carry flop live in serial_adder.

Test Plan:
- WIDTH=8, A=0x5A, B=0x33, CI=0, START pulse at E0:
  - BUSY high 8 cycles, then DONE for 1 cycle;
  - SUM=0x8D, CO=0.
- A=0xFF, B=0x01, CI=0 -> SUM=0x00, CO=1. Also A=0xFF, B=0x00, CI=1 -> SUM=0x00, CO=1.
- A=0x80, B=0x80, CI=1 -> SUM=0x01, CO=1.
  - Drive A=0x00 and pulse START at E0+3: ignored, result unchanged.
  - DONE is still high at the expected cycle.
- Back-to-back:
  - START held high from the DONE cycle with A=0x01, B=0x02, CI=0 (second op; prior result SUM=0x01, CO=1).
  - BUSY rises in the next cycle.
  - Prior SUM/CO stay stable through the second RUN, then become 0x03, 0.
- Reset mid-op: RST at E0+4 -> next cycle BUSY=0, DONE=0, SUM=0, CO=0. No DONE pulse follows.
- Random sweep, WIDTH=8 and WIDTH=2: 1000 random A, B, CI compared with a reference sum. Holds in IDLE between ops checked for SUM stability.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and legal width range.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package serial_adder_pkg;

    // Legal operand width range for serial_adder.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Sequencer states; encodings are fixed so they can be matched in debug dumps.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell used as the bit slice of the serial adder.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic SO,
    output logic CO
);

    assign SO = A ^ B ^ CI;
    assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: feeds one operand bit pair per clock through a single full_adder, LSB first.
// Latency: START accepted at E0, result and DONE pulse appear after edge E0+WIDTH; one add per WIDTH+1 cycles.
// Backpressure: none; START is ignored while BUSY, no queueing.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             CO
);

    // Reject out-of-range widths at elaboration time.
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of supported range");
    end

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    count;
    logic             fa_so;
    logic             fa_co;
    logic             load;
    logic             shift;
    logic             finish;
    logic             last;

    full_adder u_fa (
        .A  (op_a[0]),
        .B  (op_b[0]),
        .CI (carry),
        .SO (fa_so),
        .CO (fa_co)
    );

    // The bit being processed this cycle is the MSB once count reaches WIDTH-1.
    assign last = (count == CW'(WIDTH - 1));

    assign BUSY = (state == ST_RUN);
    assign DONE = (state == ST_DONE);

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                shift = 1'b1;
                if (last) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand shift registers, carry flop, partial sum and bit counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_a   <= '0;
            op_b   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
        end else if (load) begin
            op_a  <= A;
            op_b  <= B;
            carry <= CI;
            count <= '0;
        end else if (shift) begin
            op_a   <= op_a >> 1;
            op_b   <= op_b >> 1;
            sum_sh <= {fa_so, sum_sh[WIDTH-1:1]};
            carry  <= fa_co;
            // Counter saturates at WIDTH-1 so it never wraps.
            count  <= last ? count : count + 1'b1;
        end
    end

    // Parallel result registers, only updated when the MSB completes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            SUM <= '0;
            CO  <= 1'b0;
        end else if (finish) begin
            SUM <= {fa_so, sum_sh[WIDTH-1:1]};
            CO  <= fa_co;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=2.
// Directed vector table, hand-written multi-cycle sequences, then a random sweep.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       ci;
    logic       start8;
    logic       start2;
    logic       busy8, done8, co8;
    logic [7:0] sum8;
    logic       busy2, done2, co2;
    logic [1:0] sum2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst), .START(start8), .A(a_in), .B(b_in), .CI(ci),
        .BUSY(busy8), .DONE(done8), .SUM(sum8), .CO(co8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .CLK(clk), .RST(rst), .START(start2), .A(a_in[1:0]), .B(b_in[1:0]), .CI(ci),
        .BUSY(busy2), .DONE(done2), .SUM(sum2), .CO(co2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] sum;
        logic       co;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cur_busy(input bit w2);
        return w2 ? busy2 : busy8;
    endfunction

    function automatic logic cur_done(input bit w2);
        return w2 ? done2 : done8;
    endfunction

    function automatic logic [7:0] cur_sum(input bit w2);
        return w2 ? {6'b0, sum2} : sum8;
    endfunction

    function automatic logic cur_co(input bit w2);
        return w2 ? co2 : co8;
    endfunction

    // One complete operation from IDLE: checks BUSY length, result, single-cycle DONE, idle hold.
    task automatic run_op(input bit w2, input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] es, input logic eco, input string tag);
        int  w;
        int  cyc;
        bit  seen;
        w = w2 ? 2 : 8;
        a_in = a;
        b_in = b;
        ci   = c;
        if (w2) start2 = 1'b1; else start8 = 1'b1;
        tick();
        start2 = 1'b0;
        start8 = 1'b0;
        // Operands must already be captured; scramble the inputs.
        a_in = ~a;
        b_in = ~b;
        ci   = ~c;
        cyc  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (cur_done(w2)) begin
                seen = 1'b1;
            end else begin
                if (cur_busy(w2)) cyc++;
                tick();
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_cycles"}, 32'(cyc), 32'(w));
        check({tag, "_sum"}, 32'(cur_sum(w2)), 32'(es));
        check({tag, "_co"}, 32'(cur_co(w2)), 32'(eco));
        tick();
        check({tag, "_done_pulse"}, 32'(cur_done(w2)), 32'd0);
        check({tag, "_idle_sum_hold"}, 32'(cur_sum(w2)), 32'(es));
    endtask

    initial begin
        logic [8:0] full;
        logic [7:0] ra, rb, es;
        logic       rc;
        bit         stable;
        bit         seen;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        vecs[4] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[8] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};

        rst    = 1'b1;
        a_in   = '0;
        b_in   = '0;
        ci     = 1'b0;
        start8 = 1'b0;
        start2 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_sum8", 32'(sum8), 32'd0);
        check("rst_co8", 32'(co8), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        check("rst_sum2", 32'(sum2), 32'd0);

        // Directed vector table at WIDTH=8.
        for (int i = 0; i < 9; i++) begin
            run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sum, vecs[i].co,
                   $sformatf("vec%0d", i));
        end

        // START while busy is ignored; DONE still lands at E0+8.
        a_in = 8'h80; b_in = 8'h80; ci = 1'b1; start8 = 1'b1;
        tick();                                   // E0
        start8 = 1'b0;
        tick(); tick();                           // E0+2
        a_in = 8'h00; start8 = 1'b1;
        tick();                                   // E0+3
        start8 = 1'b0;
        repeat (4) tick();                        // E0+7
        check("ign_busy_e7", 32'(busy8), 32'd1);
        check("ign_done_e7", 32'(done8), 32'd0);
        tick();                                   // E0+8
        check("ign_done_e8", 32'(done8), 32'd1);
        check("ign_sum", 32'(sum8), 32'h01);
        check("ign_co", 32'(co8), 32'd1);

        // Back-to-back: START held from the DONE cycle.
        a_in = 8'h01; b_in = 8'h02; ci = 1'b0; start8 = 1'b1;
        tick();
        check("b2b_busy_rise", 32'(busy8), 32'd1);
        stable = (sum8 == 8'h01) && (co8 == 1'b1);
        for (int i = 1; i < 8; i++) begin
            tick();
            if (i == 2) start8 = 1'b0;
            if (sum8 != 8'h01 || co8 != 1'b1 || busy8 != 1'b1) stable = 1'b0;
        end
        check("b2b_prior_stable", 32'(stable), 32'd1);
        tick();
        check("b2b_done", 32'(done8), 32'd1);
        check("b2b_sum", 32'(sum8), 32'h03);
        check("b2b_co", 32'(co8), 32'd0);
        tick();
        check("b2b_idle", 32'(done8 | busy8), 32'd0);

        // Reset in the middle of an operation.
        a_in = 8'hFF; b_in = 8'hFF; ci = 1'b1; start8 = 1'b1;
        tick();                                   // E0
        start8 = 1'b0;
        repeat (3) tick();                        // E0+3
        rst = 1'b1;
        tick();                                   // E0+4
        rst = 1'b0;
        check("mrst_busy", 32'(busy8), 32'd0);
        check("mrst_done", 32'(done8), 32'd0);
        check("mrst_sum", 32'(sum8), 32'd0);
        check("mrst_co", 32'(co8), 32'd0);
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (done8) seen = 1'b1;
        end
        check("mrst_no_done", 32'(seen), 32'd0);

        // Random sweep against a reference sum, both widths.
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 1000; n++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rc = 1'($urandom);
                if (k == 1) begin
                    full = 9'(ra[1:0]) + 9'(rb[1:0]) + 9'(rc);
                    es   = {6'b0, full[1:0]};
                    run_op(1'b1, ra, rb, rc, es, full[2], "rnd2");
                end else begin
                    full = 9'(ra) + 9'(rb) + 9'(rc);
                    es   = full[7:0];
                    run_op(1'b0, ra, rb, rc, es, full[8], "rnd8");
                end
                repeat ($urandom_range(0, 2)) begin
                    a_in = 8'($urandom);
                    b_in = 8'($urandom);
                    tick();
                end
                check(k == 1 ? "rnd2_idle_hold" : "rnd8_idle_hold", 32'(cur_sum(k == 1)), 32'(es));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
